// File: rtl/arm32_pkg.sv
// Shared types and defaults for the arm32 front end.
// Fetch FSM states and the fetch packet passed from fetch to decode.
package arm32_pkg;

  localparam int          ARCH_DEF     = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ARCH_DEF-1:0] pc;
    logic [ARCH_DEF-1:0] ins;
  } fetch_pkt_t;

  localparam int PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head word is shown on pop_data.
// Power-of-two depth, pointers wrap naturally.
module sync_fifo
  import arm32_pkg::*;
#(
  parameter int WIDTH = PKT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/arm32_fetch.sv
// Instruction fetch stage: address generation, prefetch buffer,
// redirect handling and out-of-range fault, feeding arm32_decoder.
module arm32_fetch
  import arm32_pkg::*;
#(
  parameter int          ARCH       = ARCH_DEF,
  parameter int          RAM_SIZE   = 1024,
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ARCH-1:0]   mem_rdata,
  input  logic              br_valid,
  input  logic [ARCH-1:0]   br_target,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [ARCH-1:0]   ins,
  output logic [ARCH-1:0]   ins_pc,
  output logic              fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ARCH-1:0] PC_LIMIT = ARCH'(RAM_SIZE);

  fetch_state_e    state_q, state_d;
  logic [ARCH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ARCH-1:0] issue_pc_q, issue_pc_d;
  logic            inflight_q, inflight_d;
  logic            squash_q, squash_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [2*ARCH-1:0] fifo_wdata;
  logic [2*ARCH-1:0] fifo_rdata;

  logic [CW:0]     occ;
  logic            room;
  logic            pc_ok;
  logic            want;
  logic            issue;

  // In-flight requests reserve a slot so a response always has room.
  always_comb begin
    occ   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    room  = (occ < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
    pc_ok = (fetch_pc_q < PC_LIMIT);
    want  = (state_q == RUN) && room && !br_valid;
    issue = want && pc_ok;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = issue;
    squash_d   = br_valid;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (want && !pc_ok) state_d = FAULT;
      FAULT:   if (br_valid && (br_target < PC_LIMIT)) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (br_valid) begin
      fetch_pc_d = br_target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ARCH'(1);
      issue_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= ARCH'(RESET_PC);
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  assign mem_req  = issue;
  assign mem_addr = issue ? fetch_pc_q[ADDR_W-1:0] : '0;

  // Responses racing a redirect are dropped, never buffered.
  assign fifo_push  = inflight_q && !squash_q && !br_valid;
  assign fifo_wdata = {issue_pc_q, mem_rdata};
  assign ins_valid  = !fifo_empty && !br_valid;
  assign fifo_pop   = ins_valid && ins_ready;

  assign ins_pc = fifo_rdata[2*ARCH-1:ARCH];
  assign ins    = fifo_rdata[ARCH-1:0];

  assign fetch_fault = (state_q == FAULT);

  sync_fifo #(
    .WIDTH (2*ARCH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (br_valid),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_arm32_fetch.sv
// Directed bench for arm32_fetch: startup/redirect vector table plus
// backpressure, fault, mid-stream reset and redirect-vs-transfer sequences.
module tb_arm32_fetch;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              br_valid;
  logic [31:0]       br_target;
  logic              ins_valid;
  logic              ins_ready;
  logic [31:0]       ins;
  logic [31:0]       ins_pc;
  logic              fetch_fault;

  always #5 clk = ~clk;

  arm32_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .fetch_fault (fetch_fault)
  );

  function automatic logic [31:0] ramv(input logic [31:0] a);
    case (a)
      32'd0:   ramv = 32'hE3A00001;
      32'd1:   ramv = 32'hE3A01002;
      32'd2:   ramv = 32'hE0802001;
      32'd3:   ramv = 32'hEAFFFFFE;
      default: ramv = 32'hA5000000 | a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_req) mem_rdata <= ramv(32'(mem_addr));
  end

  int checks = 0;
  int errors = 0;
  int n_req  = 0;
  logic        s_req, s_vld, s_fault;
  logic [31:0] s_addr, s_pc, s_ins;
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic br,
                     input logic [31:0] tgt);
    @(negedge clk);
    reset     = rst;
    ins_ready = rdy;
    br_valid  = br;
    br_target = tgt;
    #1;
    s_req   = mem_req;
    s_addr  = 32'(mem_addr);
    s_vld   = ins_valid;
    s_pc    = ins_pc;
    s_ins   = ins;
    s_fault = fetch_fault;
    if (mem_req) n_req++;
    if (ins_valid && ins_ready) begin
      got_pc.push_back(ins_pc);
      got_ins.push_back(ins);
    end
  endtask

  task automatic wait_got(input string nm, input int n, input int budget);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      k++;
    end
    chk(nm, 32'(got_pc.size()), 32'(n));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req"},   32'(s_req), 32'd0);
    chk({nm, "_addr"},  s_addr,     32'd0);
    chk({nm, "_vld"},   32'(s_vld), 32'd0);
    chk({nm, "_ins"},   s_ins,      32'd0);
    chk({nm, "_pc"},    s_pc,       32'd0);
    chk({nm, "_fault"}, 32'(s_fault), 32'd0);
  endtask

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[15];
  int   sz;

  initial begin
    reset     = 1'b1;
    ins_ready = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;

    vt[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1,  1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 32'h1};
    vt[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h2};
    vt[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h5,  1'b1, 32'h3};
    vt[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h6,  1'b1, 32'h4};
    vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h7,  1'b1, 32'h5};
    vt[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h5};
    vt[10] = '{1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h21, 1'b0, 32'h0};
    vt[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h22, 1'b1, 32'h20};
    vt[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h23, 1'b1, 32'h21};

    // reset values
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk_zero("rst");

    // startup stream, backpressure, redirect with 5..7 buffered, 8 in flight
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, vt[i].rdy, vt[i].br, vt[i].tgt);
      chk($sformatf("v%0d_req", i), 32'(s_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("v%0d_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("v%0d_vld", i), 32'(s_vld), 32'(vt[i].e_vld));
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d_pc", i), s_pc, vt[i].e_pc);
        chk($sformatf("v%0d_ins", i), s_ins, ramv(vt[i].e_pc));
      end
      chk($sformatf("v%0d_fault", i), 32'(s_fault), 32'd0);
    end

    // backpressure from reset
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    n_req = 0;
    got_pc.delete();
    got_ins.delete();
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("bp_nreq", 32'(n_req), 32'd4);
    chk("bp_req_idle", 32'(s_req), 32'd0);
    chk("bp_vld", 32'(s_vld), 32'd1);
    chk("bp_pc", s_pc, 32'd0);
    chk("bp_ins", s_ins, 32'hE3A00001);
    wait_got("bp_cnt", 5, 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_got%0d_pc", i), got_pc[i], 32'(i));
      chk($sformatf("bp_got%0d_ins", i), got_ins[i], ramv(32'(i)));
    end

    // fault at the top of RAM
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    got_pc.delete();
    got_ins.delete();
    cyc(1'b0, 1'b1, 1'b1, 32'd1022);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_req1022", s_addr, 32'd1022);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_req1023", s_addr, 32'd1023);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_noreq", 32'(s_req), 32'd0);
    chk("flt_not_yet", 32'(s_fault), 32'd0);
    n_req = 0;
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_nreq", 32'(n_req), 32'd0);
    chk("flt_fault", 32'(s_fault), 32'd1);
    chk("flt_cnt", 32'(got_pc.size()), 32'd2);
    chk("flt_pc0", got_pc[0], 32'd1022);
    chk("flt_ins0", got_ins[0], ramv(32'd1022));
    chk("flt_pc1", got_pc[1], 32'd1023);
    cyc(1'b0, 1'b1, 1'b1, 32'd2000);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_stay", 32'(s_fault), 32'd1);
    chk("flt_stay_req", 32'(s_req), 32'd0);
    got_pc.delete();
    got_ins.delete();
    cyc(1'b0, 1'b1, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flt_clear", 32'(s_fault), 32'd0);
    chk("flt_resume", 32'(s_req), 32'd1);
    wait_got("flt_rec_cnt", 1, 10);
    chk("flt_rec_pc", got_pc[0], 32'd0);
    chk("flt_rec_ins", got_ins[0], ramv(32'd0));

    // reset with three words buffered
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("mr_vld_before", 32'(s_vld), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk_zero("mr");
    got_pc.delete();
    got_ins.delete();
    wait_got("mr_cnt", 2, 20);
    chk("mr_pc0", got_pc[0], 32'd0);
    chk("mr_ins0", got_ins[0], ramv(32'd0));
    chk("mr_pc1", got_pc[1], 32'd1);

    // redirect in a cycle that would otherwise transfer
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sz = got_pc.size();
    cyc(1'b0, 1'b1, 1'b1, 32'h100);
    chk("bx_vld", 32'(s_vld), 32'd0);
    chk("bx_noxfer", 32'(got_pc.size()), 32'(sz));
    got_pc.delete();
    got_ins.delete();
    wait_got("bx_cnt", 1, 10);
    chk("bx_pc", got_pc[0], 32'h100);
    chk("bx_ins", got_ins[0], ramv(32'h100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
